// File: rtl/svm_pkg.sv
// svm_pkg: shared defaults, label type, entry layout and FSM states for the SVM support-vector datapath.
package svm_pkg;
    localparam int N_SV = 100;
    localparam int DATA_W = 9;
    typedef logic signed [1:0] label_t;
    localparam label_t POS = 2'sd1;
    localparam label_t NEG = -2'sd1;
    typedef struct packed {
        logic [DATA_W-1:0] alpha;
        logic [DATA_W-1:0] x;
        label_t y;
    } sv_entry_t;
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
endpackage

// File: rtl/sv_mem.sv
// sv_mem: support-vector register file cleared on reset, with a checked write port and one combinational read port.
module sv_mem #(
    parameter int N_SV = 100,
    parameter int W = 20,
    parameter int ADDR_W = $clog2(N_SV)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data,
    output logic              wr_err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_data
);
    logic [W-1:0] mem [N_SV];
    logic ok;
    assign ok = en && {1'b0, wr_addr} < (ADDR_W+1)'(N_SV);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SV; i++) mem[i] <= '0;
            wr_err <= 1'b0;
        end else begin
            if (wr_en && ok) mem[wr_addr] <= wr_data;
            wr_err <= wr_en && !ok;
        end
    end
    // forward a same-cycle write so a frame starting this cycle sees it
    assign rd_data = (wr_en && ok && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
endmodule

// File: rtl/sv_streamer.sv
// sv_streamer: stores trained support vectors and replays them as one framed beat stream per test sample.
// Define SV_COUNT_EN to take the frame length from sv_count (clamped to N_SV) instead of N_SV.
module sv_streamer
    import svm_pkg::*;
#(
    parameter int N_SV = svm_pkg::N_SV,
    parameter int DATA_W = svm_pkg::DATA_W,
    parameter int ADDR_W = $clog2(N_SV),
    parameter int CNT_W = $clog2(N_SV + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_alpha,
    input  logic [DATA_W-1:0] wr_x,
    input  label_t            wr_y,
    output logic              wr_err,
    input  logic              start,
    input  logic [DATA_W-1:0] x_test_in,
    output logic              start_ready,
    input  logic [CNT_W-1:0]  sv_count,
    output logic              sv_valid,
    input  logic              sv_ready,
    output logic [DATA_W-1:0] alpha_sv,
    output logic [DATA_W-1:0] x_sv,
    output label_t            y_sv,
    output logic [DATA_W-1:0] x_test,
    output logic              sv_first,
    output logic              sv_last,
    output logic              busy,
    output logic              done
);
    localparam int W = 2 * DATA_W + 2;
    state_t state, nxt;
    logic [ADDR_W-1:0] idx, rd_addr;
    logic [CNT_W-1:0] len, len_in;
    logic [W-1:0] rd_data;
    logic go, last, adv;
`ifdef SV_COUNT_EN
    assign len_in = sv_count > CNT_W'(N_SV) ? CNT_W'(N_SV) : sv_count;
`else
    logic unused;
    assign unused = ^sv_count;
    assign len_in = CNT_W'(N_SV);
`endif
    assign go = state == IDLE && start;
    assign last = CNT_W'(idx) + CNT_W'(1) == len;
    assign adv = state == STREAM && sv_ready && !last;
    // the read port looks one entry ahead so the next beat follows without a bubble
    assign rd_addr = adv ? idx + 1'b1 : '0;
    sv_mem #(.N_SV(N_SV), .W(W), .ADDR_W(ADDR_W)) u_mem (
        .clk(clk),
        .reset(reset),
        .en(state == IDLE),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data({wr_alpha, wr_x, wr_y}),
        .wr_err(wr_err),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state == IDLE   ? (start ? (len_in == '0 ? DONE : STREAM) : IDLE) :
              state == STREAM ? (sv_ready && last ? DONE : STREAM) : IDLE;
    end
    always_comb begin
        start_ready = state == IDLE;
        busy = state != IDLE;
        sv_valid = state == STREAM;
        done = state == DONE;
        sv_first = state == STREAM && idx == '0;
        sv_last = state == STREAM && last;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            len <= '0;
            x_test <= '0;
            alpha_sv <= '0;
            x_sv <= '0;
            y_sv <= '0;
        end else if (go || adv) begin
            idx <= go ? '0 : idx + 1'b1;
            {alpha_sv, x_sv, y_sv} <= rd_data;
            if (go) begin
                len <= len_in;
                x_test <= x_test_in;
            end
        end
    end
endmodule

// File: tb/tb_sv_streamer.sv
// tb_sv_streamer: randomized bench comparing every beat of sv_streamer against an array model of the store.
module tb_sv_streamer;
    localparam int N = 100, DW = 9, AW = 7, CW = 7;
    logic clk = 0, reset = 1, wr_en = 0, start = 0, sv_ready = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_alpha = '0, wr_x = '0, x_test_in = '0;
    logic signed [1:0] wr_y = '0;
    logic [CW-1:0] sv_count = '0;
    logic wr_err, start_ready, sv_valid, sv_first, sv_last, busy, done;
    logic [DW-1:0] alpha_sv, x_sv, x_test;
    logic signed [1:0] y_sv;
    int checks = 0, errors = 0;
    int m_a[N], m_x[N], m_y[N];
    bit pre_w0 = 0;
    int w0_a, w0_x, w0_y;

    sv_streamer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_alpha(wr_alpha),
        .wr_x(wr_x), .wr_y(wr_y), .wr_err(wr_err), .start(start), .x_test_in(x_test_in),
        .start_ready(start_ready), .sv_count(sv_count), .sv_valid(sv_valid), .sv_ready(sv_ready),
        .alpha_sv(alpha_sv), .x_sv(x_sv), .y_sv(y_sv), .x_test(x_test), .sv_first(sv_first),
        .sv_last(sv_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int len_of(input int s);
`ifdef SV_COUNT_EN
        return s > N ? N : s;
`else
        return N;
`endif
    endfunction

    task automatic wr(input int a, input int al, input int x, input int y);
        @(negedge clk);
        wr_en = 1; wr_addr = AW'(a); wr_alpha = DW'(al); wr_x = DW'(x); wr_y = 2'(y);
        @(negedge clk);
        wr_en = 0;
        check("wr_err", wr_err, a >= N);
        if (a < N) begin m_a[a] = al; m_x[a] = x; m_y[a] = y; end
    endtask

    task automatic frame(input int xt, input int n, input int slen, input bit rnd,
                         input bit hold, input bit mid_wr, input int abort_at);
        int beat = 0, cyc = 1;
        @(negedge clk);
        start = 1; x_test_in = DW'(xt); sv_count = CW'(slen);
        if (pre_w0) begin
            wr_en = 1; wr_addr = 0; wr_alpha = DW'(w0_a); wr_x = DW'(w0_x); wr_y = 2'(w0_y);
            m_a[0] = w0_a; m_x[0] = w0_x; m_y[0] = w0_y; pre_w0 = 0;
        end
        sv_ready = rnd ? 1'($urandom) : 1'b1;
        @(negedge clk); cyc++;
        wr_en = 0;
        if (!hold) start = 0;
        while (!done && cyc < 3000) begin
            if (abort_at >= 0 && sv_valid && beat == abort_at) begin
                reset = 1; #1;
                check("abort_valid", sv_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_start_ready", start_ready, 1);
                check("abort_alpha", alpha_sv, 0);
                check("abort_x_test", x_test, 0);
                for (int i = 0; i < N; i++) begin m_a[i] = 0; m_x[i] = 0; m_y[i] = 0; end
                start = 0;
                @(negedge clk); reset = 0;
                repeat (4) begin @(negedge clk); check("abort_no_done", done, 0); end
                return;
            end
            check("start_ready_in_frame", start_ready, 0);
            check("busy_in_frame", busy, 1);
            if (mid_wr && cyc == 10) begin
                wr_en = 1; wr_addr = 5; wr_alpha = '1; wr_x = '1; wr_y = -2'sd1;
            end
            if (mid_wr && cyc == 11) begin
                wr_en = 0;
                check("wr_err_stream", wr_err, 1);
            end
            if (sv_valid) begin
                if (beat < n) begin
                    check("alpha", alpha_sv, m_a[beat]);
                    check("x", x_sv, m_x[beat]);
                    check("y", y_sv, m_y[beat]);
                    check("x_test", x_test, xt & 511);
                    check("sv_first", sv_first, beat == 0);
                    check("sv_last", sv_last, beat == n - 1);
                end else check("extra_beat", sv_valid, 0);
            end
            sv_ready = rnd ? 1'($urandom) : 1'b1;
            if (sv_valid && sv_ready) beat++;
            @(negedge clk); cyc++;
        end
        check("done_seen", done, 1);
        check("done_no_valid", sv_valid, 0);
        check("beat_count", beat, n);
        if (!rnd) check("done_cycle", cyc, n + 2);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", start_ready, 1);
        check("no_restart", sv_valid, 0);
        start = 0;
    endtask

    initial begin
        int s;
        repeat (2) @(negedge clk);
        check("rst_start_ready", start_ready, 1);
        check("rst_valid", sv_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_alpha", alpha_sv, 0);
        check("rst_x_test", x_test, 0);
        reset = 0;
        for (int i = 0; i < N; i++) wr(i, i, i + 1, (i % 2 == 0) ? 1 : -1);
`ifdef SV_COUNT_EN
        s = 100;
`else
        s = $urandom_range(0, 127);
`endif
        frame(7, len_of(s), s, 0, 0, 0, -1);
        frame($urandom_range(0, 511), len_of(s), s, 1, 0, 0, -1);
        wr(120, 3, 3, 1);
        frame($urandom_range(0, 511), len_of(s), s, 1, 0, 1, -1);
        frame($urandom_range(0, 511), len_of(s), s, 0, 1, 0, -1);
        pre_w0 = 1; w0_a = 300; w0_x = 411; w0_y = -1;
        frame($urandom_range(0, 511), len_of(s), s, 1, 0, 0, -1);
        frame($urandom_range(0, 511), len_of(s), s, 1, 0, 0, 40);
        frame($urandom_range(0, 511), len_of(s), s, 1, 0, 0, -1);
        for (int i = 0; i < N; i++)
            wr(i, $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 1) ? 1 : -1);
        frame($urandom_range(0, 511), len_of(s), s, 1, 0, 0, -1);
`ifdef SV_COUNT_EN
        frame($urandom_range(0, 511), 1, 1, 0, 0, 0, -1);
        frame($urandom_range(0, 511), 0, 0, 0, 0, 0, -1);
        frame($urandom_range(0, 511), 100, 127, 0, 0, 0, -1);
        frame($urandom_range(0, 511), 37, 37, 1, 0, 0, -1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sv_streamer.md
Name: sv_streamer

Overview:
- Support-vector store and streaming source for the SVM classification datapath.
- The training engine writes trained alpha, X and Y per support vector; on a test request the block replays every entry, in index order, one beat per accepted handshake.
- Each beat carries the test sample alongside, plus first/last framing, so the downstream accumulator/classifier sees one complete frame per test.

Parameters:
- N_SV, 100, number of support-vector entries stored.
- DATA_W, 9, width of alpha, X_sv and X_test (unsigned).
- ADDR_W, $clog2(N_SV), entry index width.
- CNT_W, $clog2(N_SV+1), frame-length width.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  write strobe from the trainer.
- wr_addr  in  ADDR_W  entry index to write.
- wr_alpha  in  DATA_W  alpha for the entry.
- wr_x  in  DATA_W  support-vector feature.
- wr_y  in  2 (signed)  label, +1 or -1.
- wr_err  out  1  one-cycle pulse when a write is dropped.
- start  in  1  test request.
- x_test_in  in  DATA_W  test sample, sampled when start is accepted.
- start_ready  out  1  high only in IDLE.
- sv_count  in  CNT_W  frame length; used only with SV_COUNT_EN.
- sv_valid  out  1  beat valid.
- sv_ready  in  1  downstream accepts the beat.
- alpha_sv  out  DATA_W  beat alpha.
- x_sv  out  DATA_W  beat feature.
- y_sv  out  2 (signed)  beat label.
- x_test  out  DATA_W  latched test sample, constant for the whole frame.
- sv_first  out  1  beat is entry 0.
- sv_last  out  1  beat is the final entry of the frame.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the last beat transfers.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE and the index to 0.
  - All outputs go to 0, except start_ready, which is 1 once in IDLE.
  - The memory array is cleared to zero.
  - A frame interrupted by reset is abandoned; it is not resumed and done is not pulsed.
- Memory:
  - Register array of N_SV entries, each {alpha, x, y}.
  - A write occurs on wr_en only when state is IDLE and wr_addr < N_SV.
  - Otherwise the write is dropped and wr_err pulses the next cycle.
  - Reads are combinational from the current index into the beat output registers.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - start_ready=1 and sv_valid=0.
  - On start: latch x_test_in, set idx=0, load len (N_SV, or sv_count with the macro), go to STREAM.
  - If len==0: go directly to DONE with no beats.
  - If start and wr_en occur in the same cycle, the write completes first; entry 0 reflects a write to address 0 made in that cycle.
- STREAM:
  - sv_valid=1 from the cycle after start is accepted; latency is one cycle.
  - Beat outputs hold stable while sv_valid && !sv_ready.
  - On handshake (sv_valid && sv_ready):
    - If idx != len-1: idx increments and the next entry is presented the following cycle, with no bubble.
    - If idx == len-1: sv_valid drops, go to DONE.
  - sv_first = (idx==0); sv_last = (idx==len-1); both are 1 when len==1.
- DONE: done=1 for one cycle, then IDLE. start is ignored in STREAM and DONE.
- Throughput: a len-beat frame with sv_ready held at 1 occupies len+2 cycles from start to the return to IDLE.
- Widths: unsigned data is passed through unmodified. y is stored as written; the trainer guarantees ±1, and the block does not check it.

Optional Feature:
- Macro: SV_COUNT_EN.
- Defined:
  - len = sv_count, sampled at start.
  - Values > N_SV clamp to N_SV.
  - 0 yields an empty frame: STREAM is skipped and DONE is pulsed.
- Undefined:
  - len is fixed at N_SV.
  - The sv_count port remains but is ignored.

Decomposition:
- Shared package svm_pkg holds:
  - DATA_W and N_SV defaults.
  - Label typedef (signed [1:0]), with constants POS=+1 and NEG=-1.
  - A packed struct sv_entry_t {alpha, x, y}.
  - The FSM state enum.
- One sub-module, sv_mem: the register-file array with async-reset clear, a write port with address check, and one combinational read port.
- The FSM, index counter and beat registers remain in sv_streamer.

Test Plan:
- Write entries 0..99 with alpha=i, x=i+1, y alternating +1/-1; start with x_test_in=7 and sv_ready=1 → 100 consecutive beats, beat i={i, i+1, ±1}, x_test=7, sv_first on beat 0, sv_last on beat 99, done pulse at cycle 102 after start.
- Toggle sv_ready randomly at 50% → identical beat sequence; outputs stable while stalled; no beat lost or duplicated.
- wr_en during STREAM at addr 5, and wr_addr=120 in IDLE → wr_err pulses both times; a later frame shows entry 5 unchanged.
- Assert reset at beat 40 → sv_valid=0 immediately; memory reads back all zeros; a new start streams zeros; no done pulse for the aborted frame.
- SV_COUNT_EN: sv_count=1 → one beat with sv_first=sv_last=1; sv_count=0 → done with no beats; sv_count=127 → 100 beats.
- start held high across DONE → no second frame begins until IDLE; start_ready=0 throughout the frame.
